// File: rtl/gpio_write_responder.sv
// GPIO write-port responder: LED register, byte-stream FIFO drained over valid/ready.
// Optional GPIO_DROP_COUNT_EN adds a saturating count of pushes rejected while full.
module gpio_write_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter int          DEPTH     = 8,
    parameter int          CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      GPIOaddr,
    input  logic [7:0]       GPIO,
    input  logic             GPIOEn,
    output logic [7:0]       led_out,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [CNT_W-1:0] fifo_count,
`ifdef GPIO_DROP_COUNT_EN
    output logic [7:0]       drop_count,
`endif
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next, wr_next;
    logic [CNT_W-1:0] count_next;
    logic [7:0]       head_next;
    logic [31:0]      offset;
    logic             led_we, push_req, ctrl_we, flush, clr_ovf;
    logic             full, pop, push, drop;

    // Addresses below BASE_ADDR wrap to huge offsets and fall into the ignored range.
    assign offset   = GPIOaddr - BASE_ADDR;
    assign led_we   = GPIOEn && (offset == 32'd0);
    assign push_req = GPIOEn && (offset == 32'd1);
    assign ctrl_we  = GPIOEn && (offset == 32'd2);
    assign flush    = ctrl_we && GPIO[0];
    assign clr_ovf  = ctrl_we && GPIO[1];

    assign full = (fifo_count == CNT_W'(DEPTH));
    assign pop  = tx_valid && tx_ready && !flush;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign push = push_req && (!full || pop);
    assign drop = push_req && full && !pop;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rd_next    = rd_ptr;
        wr_next    = wr_ptr;
        count_next = fifo_count;
        if (flush) begin
            rd_next    = '0;
            wr_next    = '0;
            count_next = '0;
        end else begin
            if (pop)  rd_next = rd_ptr + 1'b1;
            if (push) wr_next = wr_ptr + 1'b1;
            count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
        // The byte being written this edge bypasses the array when it becomes the new head.
        head_next = (push && (rd_next == wr_ptr)) ? GPIO : mem[rd_next];
    end

    // NOTE: the storage array has no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= GPIO;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out    <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            if (led_we) led_out <= GPIO;
            rd_ptr     <= rd_next;
            wr_ptr     <= wr_next;
            fifo_count <= count_next;
            tx_valid   <= (count_next != '0);
            tx_data    <= head_next;
            if (clr_ovf)   overflow <= 1'b0;
            else if (drop) overflow <= 1'b1;
        end
    end

`ifdef GPIO_DROP_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               drop_count <= '0;
        else if (clr_ovf)                      drop_count <= '0;
        else if (drop && drop_count != 8'hFF)  drop_count <= drop_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_gpio_write_responder.sv
// Directed bench for gpio_write_responder: vector table plus hand-written corner sequences.
module tb_gpio_write_responder;

    localparam logic [31:0] BASE = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] GPIOaddr;
    logic [7:0]  GPIO;
    logic        GPIOEn;
    logic [7:0]  led_out, tx_data;
    logic        tx_valid, tx_ready, overflow;
    logic [3:0]  fifo_count;
`ifdef GPIO_DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_write_responder #(.BASE_ADDR(BASE), .DEPTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .GPIOaddr(GPIOaddr), .GPIO(GPIO), .GPIOEn(GPIOEn),
        .led_out(led_out), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fifo_count(fifo_count),
`ifdef GPIO_DROP_COUNT_EN
        .drop_count(drop_count),
`endif
        .overflow(overflow)
    );

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic [7:0]  data;
        logic        ready;
        logic [7:0]  exp_led;
        logic [3:0]  exp_count;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive inputs just after a falling edge; they are sampled at the next rising edge.
    task automatic drive(input logic en, input logic [31:0] addr, input logic [7:0] data, input logic ready);
        GPIOEn   = en;
        GPIOaddr = addr;
        GPIO     = data;
        tx_ready = ready;
    endtask

    task automatic cycle(input logic en, input logic [31:0] addr, input logic [7:0] data, input logic ready);
        drive(en, addr, data, ready);
        @(negedge clk);
        drive(1'b0, 32'h0, 8'h00, 1'b0);
    endtask

    task automatic check_state(input string tag, input logic [7:0] led, input logic [3:0] cnt,
                               input logic valid, input logic [7:0] data, input logic ovf);
        check({tag, ".led"},   32'(led_out),    32'(led));
        check({tag, ".count"}, 32'(fifo_count), 32'(cnt));
        check({tag, ".valid"}, 32'(tx_valid),   32'(valid));
        if (valid) check({tag, ".data"}, 32'(tx_data), 32'(data));
        check({tag, ".ovf"},   32'(overflow),   32'(ovf));
    endtask

    vec_t vecs [15];
    logic [7:0] exp_drain [8];

    initial begin
        vecs[0]  = '{1'b1, BASE,              8'hA5, 1'b0, 8'hA5, 4'd0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, BASE + 32'd1,      8'h11, 1'b0, 8'hA5, 4'd1, 1'b1, 8'h11, 1'b0};
        vecs[2]  = '{1'b1, BASE + 32'd1,      8'h22, 1'b0, 8'hA5, 4'd2, 1'b1, 8'h11, 1'b0};
        vecs[3]  = '{1'b1, BASE + 32'd1,      8'h33, 1'b0, 8'hA5, 4'd3, 1'b1, 8'h11, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,             8'h00, 1'b1, 8'hA5, 4'd2, 1'b1, 8'h22, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,             8'h00, 1'b1, 8'hA5, 4'd1, 1'b1, 8'h33, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,             8'h00, 1'b1, 8'hA5, 4'd0, 1'b0, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, BASE + 32'd1,      8'h44, 1'b1, 8'hA5, 4'd1, 1'b1, 8'h44, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,             8'h00, 1'b0, 8'hA5, 4'd1, 1'b1, 8'h44, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,             8'h00, 1'b0, 8'hA5, 4'd1, 1'b1, 8'h44, 1'b0};
        vecs[10] = '{1'b1, BASE + 32'd1,      8'h55, 1'b1, 8'hA5, 4'd1, 1'b1, 8'h55, 1'b0};
        vecs[11] = '{1'b1, BASE + 32'd3,      8'hFF, 1'b0, 8'hA5, 4'd1, 1'b1, 8'h55, 1'b0};
        vecs[12] = '{1'b1, BASE - 32'd1,      8'hFF, 1'b0, 8'hA5, 4'd1, 1'b1, 8'h55, 1'b0};
        vecs[13] = '{1'b1, BASE + 32'd7,      8'hFF, 1'b0, 8'hA5, 4'd1, 1'b1, 8'h55, 1'b0};
        vecs[14] = '{1'b1, BASE + 32'd2,      8'h01, 1'b0, 8'hA5, 4'd0, 1'b0, 8'h00, 1'b0};

        rst = 1'b1;
        drive(1'b0, 32'h0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        check_state("reset", 8'h00, 4'd0, 1'b0, 8'h00, 1'b0);
        check("reset.data", 32'(tx_data), 32'h0);
`ifdef GPIO_DROP_COUNT_EN
        check("reset.drop", 32'(drop_count), 32'h0);
`endif
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].en, vecs[i].addr, vecs[i].data, vecs[i].ready);
            check_state($sformatf("vec%0d", i), vecs[i].exp_led, vecs[i].exp_count,
                        vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_ovf);
        end

        // Fill to DEPTH and attempt a ninth push (pointers are 0 after the flush above).
        for (int i = 0; i < 9; i++) cycle(1'b1, BASE + 32'd1, 8'h80 + 8'(i), 1'b0);
        check_state("full", 8'hA5, 4'd8, 1'b1, 8'h80, 1'b1);
`ifdef GPIO_DROP_COUNT_EN
        check("full.drop", 32'(drop_count), 32'd1);
`endif
        cycle(1'b1, BASE + 32'd2, 8'h02, 1'b0);
        check_state("clr_ovf", 8'hA5, 4'd8, 1'b1, 8'h80, 1'b0);
`ifdef GPIO_DROP_COUNT_EN
        check("clr_ovf.drop", 32'(drop_count), 32'd0);
`endif

        // Push and pop on the same edge while full: 0x80 leaves, 0x99 lands in wrapped slot 0.
        cycle(1'b1, BASE + 32'd1, 8'h99, 1'b1);
        check_state("full_pp", 8'hA5, 4'd8, 1'b1, 8'h81, 1'b0);
        for (int i = 0; i < 7; i++) exp_drain[i] = 8'h81 + 8'(i);
        exp_drain[7] = 8'h99;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d.valid", i), 32'(tx_valid), 32'd1);
            check($sformatf("drain%0d.data", i), 32'(tx_data), 32'(exp_drain[i]));
            cycle(1'b0, 32'h0, 8'h00, 1'b1);
        end
        check_state("drained", 8'hA5, 4'd0, 1'b0, 8'h00, 1'b0);

        // Flush with a pending pop: flush wins.
        for (int i = 0; i < 5; i++) cycle(1'b1, BASE + 32'd1, 8'hC0 + 8'(i), 1'b0);
        check_state("five", 8'hA5, 4'd5, 1'b1, 8'hC0, 1'b0);
        cycle(1'b1, BASE + 32'd2, 8'h01, 1'b1);
        check_state("flush_pop", 8'hA5, 4'd0, 1'b0, 8'h00, 1'b0);

        // Async reset between edges with four bytes queued.
        for (int i = 0; i < 4; i++) cycle(1'b1, BASE + 32'd1, 8'hD0 + 8'(i), 1'b0);
        check_state("four", 8'hA5, 4'd4, 1'b1, 8'hD0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_state("async_rst", 8'h00, 4'd0, 1'b0, 8'h00, 1'b0);
        check("async_rst.data", 32'(tx_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, BASE + 32'd1, 8'hE7, 1'b0);
        check_state("post_rst", 8'h00, 4'd1, 1'b1, 8'hE7, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_write_responder.md
Name: gpio_write_responder

Overview:
- Peripheral-side responder for the processor's GPIO write port (32-bit address, 8-bit data, one-cycle enable strobe).
- Decodes strobed writes within a small address window:
  - Drives a latched 8-bit output register.
  - Queues stream bytes in a FIFO.
  - Drains the FIFO to a downstream consumer over a valid/ready handshake.
- Sits outside the CPU, between its GPIO pins and board-level sinks (LEDs, serial transmitter).

Parameters:
- BASE_ADDR, 32'h0000_0400, word address of register 0 of the window.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 4, width of the fill count; equals log2(DEPTH)+1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- GPIOaddr  in  32  write address from the CPU; qualified by GPIOEn.
- GPIO  in  8  write data from the CPU; qualified by GPIOEn.
- GPIOEn  in  1  write strobe; each high cycle is one independent write.
- led_out  out  8  latched output register.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts tx_data when tx_valid&tx_ready.
- fifo_count  out  CNT_W  current number of entries.
- overflow  out  1  sticky flag: a push was attempted while full.

Behaviour:
- Reset (async assert, sync-safe release):
  - led_out=0, tx_valid=0, tx_data=0, fifo_count=0, overflow=0.
  - Read and write pointers = 0.
- Address decode: offset = GPIOaddr - BASE_ADDR, evaluated only when GPIOEn=1.
  - Offset 0 (LED): led_out <= GPIO next edge; latency 1 cycle.
  - Offset 1 (PUSH): enqueue GPIO if not full. If full, data is discarded and overflow <= 1.
  - Offset 2 (CTRL):
    - GPIO[0]=1: flush FIFO (pointers and count to 0).
    - GPIO[1]=1: clear overflow.
    - Both bits may be set in one write.
  - Offsets >= 3, or addresses below BASE_ADDR: ignored, no state change.
- FIFO:
  - Circular buffer with DEPTH entries; pointers wrap modulo DEPTH.
  - fifo_count ranges 0..DEPTH.
  - full = (count==DEPTH); empty = (count==0).
  - tx_valid = !empty, registered with the count.
  - tx_data = mem[rd_ptr], a registered/synchronous view. A byte pushed into an empty FIFO is visible on tx_data/tx_valid one cycle after the strobe edge.
- Handshake:
  - Pop occurs on an edge where tx_valid&tx_ready.
  - tx_data must stay stable while tx_valid=1 and tx_ready=0.
  - tx_ready while empty has no effect.
- Simultaneous events, same edge:
  - Push and pop, not empty: both occur; count unchanged; pointers advance.
  - Push and pop when full: the pop frees a slot, so the push is accepted and overflow is not set.
  - Push when empty with tx_ready=1: push only, because tx_valid was 0.
  - Flush with a pending pop: flush wins; the pop is ignored.
- GPIOEn high on consecutive cycles: each cycle is an independent write, with no throughput limit.
- rst asserted mid-transfer: all state returns to reset values immediately, and in-flight FIFO contents are lost.

Optional Feature:
- Macro: GPIO_DROP_COUNT_EN.
- Enabled:
  - Adds output drop_count[7:0]. It increments on every push rejected while full and saturates at 8'hFF.
  - Cleared by reset and by CTRL GPIO[1]=1, together with overflow.
- Disabled: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then LED write: write addr=BASE_ADDR, data=8'hA5 -> led_out=8'hA5 one cycle later; tx_valid stays 0.
- Ordered push/drain: push 8'h11, 8'h22, 8'h33 at BASE_ADDR+1 with tx_ready=0 -> fifo_count=3, tx_data=8'h11. Then set tx_ready=1 -> bytes 11,22,33 accepted in order on consecutive cycles, then tx_valid=0.
- Full/overflow with DEPTH=8:
  - Push 9 bytes with tx_ready=0 -> count=8, overflow=1, 9th byte never emitted; drop_count=1 when GPIO_DROP_COUNT_EN.
  - CTRL write 8'h02 -> overflow=0.
- Simultaneous push+pop while full: count stays 8, overflow stays 0, and the pushed byte emerges after the 7 older bytes (pointer wrap verified).
- Flush and decode: CTRL write 8'h01 while count=5 with tx_ready=1 -> count=0, tx_valid=0 next cycle. A write at BASE_ADDR+7 or BASE_ADDR-1 -> no change to any output.
- Async reset mid-stream: assert rst between clock edges while count=4 -> all outputs zero immediately; after release, a single push yields count=1.
